// File: rtl/mac_pkg.sv
// Shared types for the MAC stream controller: FSM states and the result record.
package mac_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_ACC_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    LOAD,
    STREAM,
    DRAIN
  } mac_ctrl_state_t;

  typedef struct packed {
    logic [MAC_ACC_W-1:0] data;
    logic                 last;
  } mac_result_t;

endpackage

// File: rtl/mac_res_fifo.sv
// Synchronous result FIFO with occupancy count; reads come straight from the head entry.
module mac_res_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents are only observed through a valid head pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mac_stream_ctrl.sv
// Sequencer that loads a weight into the MAC, streams activations under a
// result-FIFO credit limit, and tags the final result of each command.
module mac_stream_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_W     = MAC_DATA_W,
  parameter int ACC_W      = MAC_ACC_W,
  parameter int LEN_W      = 8,
  parameter int MAC_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_weight,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_data,
  output logic [DATA_W-1:0] mac_weight_in,
  output logic              mac_preload_weight,
  output logic              mac_load_weight,
  output logic              mac_enable,
  output logic [DATA_W-1:0] mac_input_val,
  input  logic [ACC_W-1:0]  mac_out,
  input  logic              mac_out_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_last,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mac_ctrl_state_t   state_q, state_d;
  logic [DATA_W-1:0] weight_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [CW-1:0]     inflight_q;
  logic [MAC_LAT:0]  tag_q;
  logic              enable_q;
  logic [DATA_W-1:0] input_val_q;
  logic              err_q;

  logic              cmd_hs, act_hs, last_hs, ret, pop;
  logic [CW:0]       used;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  mac_result_t       fifo_in, fifo_out;

  // A pop frees its slot in the same cycle, so it is taken off the occupancy.
  assign used    = (CW+1)'(fifo_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign cmd_hs  = cmd_valid && (state_q == IDLE);
  assign act_hs  = act_valid && act_ready;
  assign last_hs = act_hs && (remaining_q == LEN_W'(1));
  assign ret     = mac_out_valid && (inflight_q != '0);
  assign pop     = res_valid && res_ready;

  assign cmd_ready          = (state_q == IDLE);
  assign act_ready          = (state_q == STREAM) && (remaining_q != '0) &&
                              (used < (CW+1)'(FIFO_DEPTH));
  assign mac_weight_in      = weight_q;
  assign mac_preload_weight = (state_q == PRELOAD);
  assign mac_load_weight    = (state_q == LOAD);
  assign mac_enable         = enable_q;
  assign mac_input_val      = input_val_q;
  assign res_valid          = !fifo_empty;
  assign res_data           = fifo_empty ? '0 : fifo_out.data;
  assign res_last           = fifo_empty ? 1'b0 : fifo_out.last;
  assign busy               = (state_q != IDLE) || !fifo_empty;
  assign err                = err_q;

  assign fifo_in.data = mac_out;
  assign fifo_in.last = tag_q[MAC_LAT];

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: one cycle each for preload and load, then stream and drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs) state_d = PRELOAD;
      PRELOAD: state_d = LOAD;
      LOAD:    state_d = (remaining_q != '0) ? STREAM : IDLE;
      STREAM:  if (last_hs) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, activation issue stage, in-flight credits, last-tag pipe and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_q    <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
      tag_q       <= '0;
      enable_q    <= 1'b0;
      input_val_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (cmd_hs) begin
        weight_q    <= cmd_weight;
        remaining_q <= cmd_len;
      end else if (act_hs) begin
        remaining_q <= remaining_q - LEN_W'(1);
      end
      inflight_q  <= inflight_q + CW'(act_hs) - CW'(ret);
      tag_q       <= {tag_q[MAC_LAT-1:0], last_hs};
      enable_q    <= act_hs;
      input_val_q <= act_hs ? act_data : '0;
      if (mac_out_valid && (inflight_q == '0)) err_q <= 1'b1;
    end
  end

  mac_res_fifo #(
    .WIDTH ($bits(mac_result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ret),
    .push_data_i (fifo_in),
    .pop_i       (pop),
    .pop_data_o  (fifo_out),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // The credit limit must make a push into a full FIFO impossible.
  ap_no_overflow: assert property (@(posedge clk) disable iff (reset) !(ret && fifo_full));

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Directed bench for mac_stream_ctrl with a behavioural MAC attached to its pins.
`timescale 1ns/1ps
module tb_mac_stream_ctrl;

  localparam int DATA_W = 8, ACC_W = 16, LEN_W = 8, MAC_LAT = 2, FIFO_DEPTH = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [DATA_W-1:0] cmd_weight = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic act_valid = 1'b0, act_ready;
  logic [DATA_W-1:0] act_data = '0;
  logic [DATA_W-1:0] mac_weight_in, mac_input_val;
  logic mac_preload_weight, mac_load_weight, mac_enable;
  logic [ACC_W-1:0] mac_out;
  logic mac_out_valid;
  logic res_valid, res_ready = 1'b1, res_last, busy, err;
  logic [ACC_W-1:0] res_data;

  int checks = 0, failures = 0;
  int enable_count = 0, act_ready_seen = 0;
  logic [ACC_W-1:0] got_data [$];
  logic got_last [$];
  logic [DATA_W-1:0] act_vals [16];

  // Free-running clock.
  always #5 clk = ~clk;

  mac_stream_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_weight(cmd_weight), .cmd_len(cmd_len),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .mac_weight_in(mac_weight_in), .mac_preload_weight(mac_preload_weight),
    .mac_load_weight(mac_load_weight), .mac_enable(mac_enable), .mac_input_val(mac_input_val),
    .mac_out(mac_out), .mac_out_valid(mac_out_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .err(err)
  );

  // Behavioural MAC: preload stages a weight, load commits it and clears the
  // accumulator, each enable accumulates w*x and returns it MAC_LAT cycles later.
  logic [ACC_W-1:0] pipe_d [MAC_LAT];
  logic pipe_v [MAC_LAT];
  logic [DATA_W-1:0] w_pre, w_act;
  logic [ACC_W-1:0] acc, acc_next;
  logic spur = 1'b0;

  assign acc_next      = acc + ACC_W'(w_act) * ACC_W'(mac_input_val);
  assign mac_out_valid = pipe_v[MAC_LAT-1] | spur;
  assign mac_out       = spur ? 16'hBEEF : pipe_d[MAC_LAT-1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      w_pre <= '0; w_act <= '0; acc <= '0;
      for (int k = 0; k < MAC_LAT; k++) begin pipe_d[k] <= '0; pipe_v[k] <= 1'b0; end
    end else begin
      if (mac_preload_weight) w_pre <= mac_weight_in;
      if (mac_load_weight) begin w_act <= w_pre; acc <= '0; end
      else if (mac_enable) acc <= acc_next;
      pipe_v[0] <= mac_enable;
      pipe_d[0] <= acc_next;
      for (int k = 1; k < MAC_LAT; k++) begin pipe_v[k] <= pipe_v[k-1]; pipe_d[k] <= pipe_d[k-1]; end
    end
  end

  // Record every result handshake plus enable and act_ready activity, sampled mid-cycle.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin got_data.push_back(res_data); got_last.push_back(res_last); end
    if (mac_enable) enable_count++;
    if (act_ready) act_ready_seen++;
  end

  // Offer one command and return one cycle after its handshake (in PRELOAD).
  task automatic send_cmd(input logic [DATA_W-1:0] w, input logic [LEN_W-1:0] n);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_weight = w; cmd_len = n;
    for (int b = 0; b < 100; b++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL cmd_handshake: got no cmd_ready, expected 1 within 100 cycles"); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Stream act_vals[0..n-1], one handshake per value.
  task automatic send_acts(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      act_valid = 1'b1; act_data = act_vals[i]; ok = 0;
      for (int b = 0; b < 200; b++) begin
        @(negedge clk);
        if (act_ready) begin ok = 1; break; end
        @(posedge clk); #1;
      end
      if (!ok) begin
        checks++; failures++;
        $display("[TB] FAIL act_handshake: got no act_ready for item %0d, expected 1 within 200 cycles", i);
        break;
      end
      @(posedge clk); #1;
    end
    act_valid = 1'b0;
  endtask

  // Wait (bounded) until n results are collected.
  task automatic wait_results(input int n);
    bit ok = 0;
    for (int b = 0; b < 300; b++) begin
      @(posedge clk); #1;
      if (got_data.size() >= n) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL result_count: got %0d results, expected %0d", got_data.size(), n); end
  endtask

  // Wait (bounded) until the controller is idle with an empty FIFO.
  task automatic wait_idle();
    bit ok = 0;
    for (int b = 0; b < 300; b++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL idle_wait: got busy=1, expected 0 within 300 cycles"); end
  endtask

  // Outputs held in reset, then released.
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_cmd_ready: got %0b expected 1", cmd_ready); end
    checks++; if (act_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_act_ready: got %0b expected 0", act_ready); end
    checks++; if ({mac_preload_weight, mac_load_weight, mac_enable} !== 3'b000) begin failures++; $display("[TB] FAIL rst_mac_pulses: got %b expected 000", {mac_preload_weight, mac_load_weight, mac_enable}); end
    checks++; if ({mac_weight_in, mac_input_val} !== 16'h0000) begin failures++; $display("[TB] FAIL rst_mac_data: got %h expected 0000", {mac_weight_in, mac_input_val}); end
    checks++; if ({res_valid, res_last, busy, err} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_flags: got %b expected 0000", {res_valid, res_last, busy, err}); end
    checks++; if (res_data !== 16'h0000) begin failures++; $display("[TB] FAIL rst_res_data: got %h expected 0000", res_data); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Preload/load pulse placement and weight output (weight 0x5A, one activation of 2).
  task automatic test_preload();
    got_data.delete(); got_last.delete();
    act_vals[0] = 8'd2;
    send_cmd(8'h5A, 8'd1);
    checks++; if ({mac_preload_weight, mac_load_weight} !== 2'b10) begin failures++; $display("[TB] FAIL pre_t1_pulses: got %b expected 10", {mac_preload_weight, mac_load_weight}); end
    checks++; if (mac_weight_in !== 8'h5A) begin failures++; $display("[TB] FAIL pre_t1_weight: got %h expected 5a", mac_weight_in); end
    @(posedge clk); #1;
    checks++; if ({mac_preload_weight, mac_load_weight} !== 2'b01) begin failures++; $display("[TB] FAIL pre_t2_pulses: got %b expected 01", {mac_preload_weight, mac_load_weight}); end
    send_acts(1);
    checks++; if ({mac_preload_weight, mac_load_weight} !== 2'b00) begin failures++; $display("[TB] FAIL pre_after_pulses: got %b expected 00", {mac_preload_weight, mac_load_weight}); end
    checks++; if (mac_weight_in !== 8'h5A) begin failures++; $display("[TB] FAIL pre_weight_hold: got %h expected 5a", mac_weight_in); end
    wait_results(1);
    checks++; if (got_data.size() < 1 || got_data[0] !== 16'h00B4 || got_last[0] !== 1'b1) begin failures++; $display("[TB] FAIL pre_result: got %h/%0d expected 00b4 last=1", (got_data.size() > 0) ? got_data[0] : 16'hxxxx, got_data.size()); end
    wait_idle();
  endtask

  // Weight 3 over activations 1..4 gives 3,9,18,30 with last only on 30.
  task automatic test_basic();
    logic [ACC_W-1:0] exp_d [4] = '{16'd3, 16'd9, 16'd18, 16'd30};
    bit ok = 0;
    got_data.delete(); got_last.delete();
    act_vals[0] = 8'd1; act_vals[1] = 8'd2; act_vals[2] = 8'd3; act_vals[3] = 8'd4;
    send_cmd(8'd3, 8'd4);
    send_acts(4);
    for (int b = 0; b < 100; b++) begin
      @(negedge clk);
      if (res_valid && res_last) begin ok = 1; break; end
    end
    checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_last_seen: got no res_last, expected one within 100 cycles"); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_at_pop: got %0b expected 1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after_pop: got %0b expected 0", busy); end
    checks++; if (got_data.size() != 4) begin failures++; $display("[TB] FAIL basic_count: got %0d expected 4", got_data.size()); end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin failures++; $display("[TB] FAIL basic_result%0d: got %0d last=%0b expected %0d last=%0b", i, got_data[i], got_last[i], exp_d[i], (i == 3)); end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL basic_err: got %0b expected 0", err); end
  endtask

  // Zero-length command: pulses only, no activations accepted, no results.
  task automatic test_len_zero();
    got_data.delete(); got_last.delete();
    act_valid = 1'b1; act_data = 8'd9; act_ready_seen = 0;
    send_cmd(8'd5, 8'd0);
    checks++; if (mac_preload_weight !== 1'b1) begin failures++; $display("[TB] FAIL len0_preload: got %0b expected 1", mac_preload_weight); end
    @(posedge clk); #1;
    checks++; if (mac_load_weight !== 1'b1) begin failures++; $display("[TB] FAIL len0_load: got %0b expected 1", mac_load_weight); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL len0_cmd_ready_t3: got %0b expected 1", cmd_ready); end
    checks++; if (mac_weight_in !== 8'd5) begin failures++; $display("[TB] FAIL len0_weight_hold: got %0d expected 5", mac_weight_in); end
    repeat (5) @(posedge clk); #1;
    act_valid = 1'b0;
    checks++; if (act_ready_seen != 0) begin failures++; $display("[TB] FAIL len0_act_ready: got %0d ready cycles expected 0", act_ready_seen); end
    checks++; if (got_data.size() != 0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL len0_no_results: got %0d results busy=%0b expected 0 results busy=0", got_data.size(), busy); end
  endtask

  // res_ready low: only FIFO_DEPTH enables issue; release and all 10 arrive in order.
  task automatic test_back_to_back();
    got_data.delete(); got_last.delete();
    for (int i = 0; i < 10; i++) act_vals[i] = DATA_W'(i + 1);
    res_ready = 1'b0; enable_count = 0;
    send_cmd(8'd2, 8'd10);
    fork
      send_acts(10);
      begin
        repeat (20) @(posedge clk); #1;
        checks++; if (enable_count != FIFO_DEPTH) begin failures++; $display("[TB] FAIL bp_enables: got %0d expected %0d", enable_count, FIFO_DEPTH); end
        checks++; if (act_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_act_ready: got %0b expected 0", act_ready); end
        checks++; if (res_valid !== 1'b1 || res_data !== 16'd2 || res_last !== 1'b0) begin failures++; $display("[TB] FAIL bp_head_hold: got v=%0b d=%0d l=%0b expected v=1 d=2 l=0", res_valid, res_data, res_last); end
        res_ready = 1'b1;
      end
    join
    wait_results(10);
    for (int k = 0; k < 10 && k < got_data.size(); k++) begin
      checks++; if (got_data[k] !== ACC_W'((k + 1) * (k + 2)) || got_last[k] !== (k == 9)) begin failures++; $display("[TB] FAIL bp_result%0d: got %0d last=%0b expected %0d last=%0b", k, got_data[k], got_last[k], (k + 1) * (k + 2), (k == 9)); end
    end
    wait_idle();
    checks++; if (enable_count != 10) begin failures++; $display("[TB] FAIL bp_total_enables: got %0d expected 10", enable_count); end
  endtask

  // mac_out_valid with nothing outstanding sets a sticky error and is dropped.
  task automatic test_spurious();
    got_data.delete(); got_last.delete();
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL spur_err_set: got %0b expected 1", err); end
    repeat (3) @(posedge clk); #1;
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL spur_err_sticky: got %0b expected 1", err); end
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || got_data.size() != 0) begin failures++; $display("[TB] FAIL spur_fifo_empty: got v=%0b busy=%0b n=%0d expected 0 0 0", res_valid, busy, got_data.size()); end
  endtask

  // Reset after 2 of 6 activations, then a fresh command (w=1: 5,6,7 -> 5,11,18).
  task automatic test_reset_midstream();
    logic [ACC_W-1:0] exp_d [3] = '{16'd5, 16'd11, 16'd18};
    for (int i = 0; i < 6; i++) act_vals[i] = DATA_W'(i + 1);
    send_cmd(8'd4, 8'd6);
    send_acts(2);
    reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1 || act_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ready: got cmd=%0b act=%0b expected 1 0", cmd_ready, act_ready); end
    checks++; if ({mac_preload_weight, mac_load_weight, mac_enable} !== 3'b000 || {mac_weight_in, mac_input_val} !== 16'h0000) begin failures++; $display("[TB] FAIL mid_rst_mac: got %b %h expected 000 0000", {mac_preload_weight, mac_load_weight, mac_enable}, {mac_weight_in, mac_input_val}); end
    checks++; if ({res_valid, res_last, busy, err} !== 4'b0000 || res_data !== 16'h0000) begin failures++; $display("[TB] FAIL mid_rst_flags: got %b %h expected 0000 0000", {res_valid, res_last, busy, err}, res_data); end
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_cmd_ready: got %0b expected 1", cmd_ready); end
    got_data.delete(); got_last.delete();
    act_vals[0] = 8'd5; act_vals[1] = 8'd6; act_vals[2] = 8'd7;
    send_cmd(8'd1, 8'd3);
    send_acts(3);
    wait_results(3);
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 2)) begin failures++; $display("[TB] FAIL mid_result%0d: got %0d last=%0b expected %0d last=%0b", i, got_data[i], got_last[i], exp_d[i], (i == 2)); end
    end
    wait_idle();
    checks++; if (err !== 1'b0 || got_data.size() != 3) begin failures++; $display("[TB] FAIL mid_final: got err=%0b n=%0d expected 0 3", err, got_data.size()); end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_len_zero();
    test_back_to_back();
    test_spurious();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence above never completes.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mac_stream_ctrl.md
# mac_stream_ctrl

Initiator-side sequencer for the Best_MAC port interface. Accepts a command (one weight plus an activation count) and an activation stream. It drives the MAC's preload/load/enable/input_val pins and collects mac_out/out_valid into a credit-protected result FIFO with valid/ready output. It sits between the activation buffer and the downstream accumulator/writeback in the MAC datapath.

## Interface
- DATA_W, 8, weight/activation width
- ACC_W, 16, MAC result width (2*DATA_W)
- LEN_W, 8, activation-count width
- MAC_LAT, 2, cycles from a mac_enable cycle to the matching mac_out_valid, ≥1
- FIFO_DEPTH, 4, result FIFO entries, power of two, ≥2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_weight  in  DATA_W  weight for this command
- cmd_len  in  LEN_W  number of activations, 0 is legal
- act_valid  in  1  activation offered
- act_ready  out  1  activation accepted this cycle
- act_data  in  DATA_W  activation value
- mac_weight_in  out  DATA_W  to MAC weight_in
- mac_preload_weight  out  1  to MAC preload_weight
- mac_load_weight  out  1  to MAC load_weight
- mac_enable  out  1  to MAC enable
- mac_input_val  out  DATA_W  to MAC input_val
- mac_out  in  ACC_W  from MAC mac_out
- mac_out_valid  in  1  from MAC out_valid
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  ACC_W  result
- res_last  out  1  result belongs to the command's final activation
- busy  out  1  state≠IDLE or FIFO non-empty
- err  out  1  sticky: mac_out_valid arrived with nothing in flight; cleared by reset only

## Operation
- FSM states: IDLE, PRELOAD, LOAD, STREAM, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch weight/len and go to PRELOAD.
- PRELOAD: one cycle. mac_preload_weight=1, mac_weight_in=weight. Go to LOAD.
- LOAD: one cycle. mac_load_weight=1. Go to STREAM if len≠0, else IDLE (no results produced).
- STREAM: act_ready = (remaining≠0) & (fifo_count + inflight < FIFO_DEPTH). Each act handshake decrements remaining and increments inflight. When the last activation is accepted, go to DRAIN.
- DRAIN: wait for inflight=0, then go to IDLE.
- inflight counts issued enables (including the registered output stage) not yet returned. It decrements on mac_out_valid.
- Tag pipe: a MAC_LAT+1 deep shift register carries a last bit alongside each issue. The bit is written to the FIFO with mac_out.
- mac_out_valid with inflight=0: drop the data, set err.
- The credit rule guarantees no FIFO overflow. A push into a full FIFO is a design error (assertion).
- mac_weight_in holds the latched weight outside PRELOAD. The pulse outputs are 0 outside their states.

## Timing
- Reset values: cmd_ready=1 (IDLE), act_ready=0, all mac_* outputs 0, res_valid=0, res_data=0, res_last=0, busy=0, err=0. Reset mid-command clears the FSM, counters, tag pipe and FIFO; pending results are lost.
- Command accepted at cycle T: PRELOAD at T+1, LOAD at T+2, first act_ready possible at T+3.
- Activation handshake at cycle S: mac_enable=1 and mac_input_val=act_data are registered and appear at S+1.
- The MAC returns mac_out_valid at S+1+MAC_LAT. The FIFO writes then, and res_valid can rise the following cycle (no bypass).
- Full throughput is one activation per cycle when FIFO_DEPTH ≥ MAC_LAT+2 and res_ready is held high.
- res_valid/res_data/res_last are stable while res_valid & !res_ready.
- Simultaneous push and pop on the FIFO is allowed at any occupancy below full. A pop frees a credit in the same cycle it occurs.

## Structure
- Package mac_pkg: the state enum typedef mac_ctrl_state_t, and a result struct typedef {logic [ACC_W-1:0] data; logic last;}.
- Sub-module mac_res_fifo: a synchronous FIFO, parameterised by width and depth, exposing count, full and empty. All other logic lives in mac_stream_ctrl.

## Test plan
- Basic: weight=3, len=4, activations 1,2,3,4, model MAC (acc += w*x, MAC_LAT=2), res_ready=1 → results 3,9,18,30. res_last only on 30. busy falls 1 cycle after the final pop.
- Preload pulse: after a command handshake at T → mac_preload_weight=1 only at T+1 and mac_load_weight=1 only at T+2, with mac_weight_in=cmd_weight.
- len=0: weight=5 → preload/load pulses occur, no act_ready, no results, cmd_ready=1 again at T+3.
- Backpressure: len=10, res_ready=0 → at most FIFO_DEPTH enables are issued, act_ready stays 0. Releasing res_ready → all 10 results arrive in order, no loss.
- Spurious return: mac_out_valid pulsed in IDLE → err=1 and stays 1, FIFO stays empty.
- Reset mid-STREAM: reset asserted after 2 of 6 activations → all outputs return to reset values, cmd_ready=1 after deassertion, and a new command runs correctly.
